// File: rtl/student_fir_sample_feeder.sv
// student_fir_sample_feeder: host-side sample FIFO and strobe sequencer
// feeding student_fir, one sample in flight at a time.
//
// Ports:
//   clk_i, rst_ni         clock, async active-low reset
//   enable_i              allow new transactions to start
//   wr_valid_i/wr_data_i  host sample push
//   wr_ready_o, level_o   FIFO not full, FIFO occupancy
//   valid_strobe_o        strobe to FIR, held STROBE_CYCLES
//   sample_o              sample to FIR
//   fir_done_i, y_i       completion strobe and result from FIR
//   y_o, y_valid_o        captured result, 1-cycle update pulse
//   busy_o                transaction in progress
//   timeout_o, clr_err_i  sticky timeout flag and its clear
// Macro STUDENT_FIR_FEEDER_STATS_EN adds sent_cnt_o and timeout_cnt_o.
module student_fir_sample_feeder #(
  parameter int DATA_SIZE      = 16,
  parameter int DATA_SIZE_Y    = 32,
  parameter int FIFO_DEPTH     = 8,
  parameter int STROBE_CYCLES  = 2,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          enable_i,
  input  logic                          wr_valid_i,
  input  logic [DATA_SIZE-1:0]          wr_data_i,
  output logic                          wr_ready_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          valid_strobe_o,
  output logic [DATA_SIZE-1:0]          sample_o,
  input  logic                          fir_done_i,
  input  logic [DATA_SIZE_Y-1:0]        y_i,
  output logic [DATA_SIZE_Y-1:0]        y_o,
  output logic                          y_valid_o,
  output logic                          busy_o,
  output logic                          timeout_o,
  input  logic                          clr_err_i
`ifdef STUDENT_FIR_FEEDER_STATS_EN
  ,
  output logic [15:0]                   sent_cnt_o,
  output logic [15:0]                   timeout_cnt_o
`endif
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int SG   = (STROBE_CYCLES > GAP_CYCLES) ?
                        STROBE_CYCLES : GAP_CYCLES;
  localparam int CMAX = (TIMEOUT_CYCLES > SG) ?
                        TIMEOUT_CYCLES : SG;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT,
    S_GAP
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_SIZE-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]          level_q, level_d;
  logic                   done_q;
  logic                   strobe_q, strobe_d;
  logic [DATA_SIZE-1:0]   sample_q, sample_d;
  logic [DATA_SIZE_Y-1:0] y_q, y_d;
  logic                   yv_q, yv_d;
  logic                   tmo_q, tmo_set;
  logic                   push, pop, done_rise;

  assign wr_ready_o     = (level_q != LW'(FIFO_DEPTH));
  assign level_o        = level_q;
  assign valid_strobe_o = strobe_q;
  assign sample_o       = sample_q;
  assign y_o            = y_q;
  assign y_valid_o      = yv_q;
  assign busy_o         = (state_q != S_IDLE);
  assign timeout_o      = tmo_q;

  assign push      = wr_valid_i && wr_ready_o;
  assign pop       = (state_q == S_IDLE) && enable_i &&
                     (level_q != '0);
  // done_q tracks fir_done_i in every state, so a level already
  // high on WAIT entry never looks like a fresh edge.
  assign done_rise = fir_done_i && !done_q;

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    strobe_d = strobe_q;
    sample_d = sample_q;
    y_d      = y_q;
    yv_d     = 1'b0;
    tmo_set  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          sample_d = mem[rd_ptr_q];
          strobe_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_STROBE;
        end
      end
      S_STROBE: begin
        if (cnt_q == CW'(STROBE_CYCLES - 1)) begin
          strobe_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (done_rise) begin
          y_d     = y_i;
          yv_d    = 1'b1;
          cnt_d   = '0;
          state_d = S_GAP;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          tmo_set = 1'b1;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      done_q   <= 1'b0;
      strobe_q <= 1'b0;
      sample_q <= '0;
      y_q      <= '0;
      yv_q     <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      done_q   <= fir_done_i;
      strobe_q <= strobe_d;
      sample_q <= sample_d;
      y_q      <= y_d;
      yv_q     <= yv_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (tmo_set)        tmo_q <= 1'b1;
      else if (clr_err_i) tmo_q <= 1'b0;
    end
  end

`ifdef STUDENT_FIR_FEEDER_STATS_EN
  logic [15:0] sent_q, tcnt_q;

  assign sent_cnt_o    = sent_q;
  assign timeout_cnt_o = tcnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sent_q <= '0;
      tcnt_q <= '0;
    end else begin
      if (pop && sent_q != 16'hFFFF)
        sent_q <= sent_q + 16'd1;
      if (clr_err_i)
        tcnt_q <= tmo_set ? 16'd1 : 16'd0;
      else if (tmo_set && tcnt_q != 16'hFFFF)
        tcnt_q <= tcnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_student_fir_sample_feeder.sv
// tb_student_fir_sample_feeder: scoreboard bench for the FIR
// sample feeder with a delayed-response FIR model.
module tb_student_fir_sample_feeder;

  localparam int DW    = 16;
  localparam int YW    = 32;
  localparam int DEPTH = 8;
  localparam int STB   = 2;
  localparam int GAP   = 4;
  localparam int TMO   = 64;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          enable_i = 1'b0;
  logic          wr_valid_i = 1'b0;
  logic [DW-1:0] wr_data_i = '0;
  logic          wr_ready_o;
  logic [3:0]    level_o;
  logic          valid_strobe_o;
  logic [DW-1:0] sample_o;
  logic          fir_done_i;
  logic [YW-1:0] y_i;
  logic [YW-1:0] y_o;
  logic          y_valid_o;
  logic          busy_o;
  logic          timeout_o;
  logic          clr_err_i = 1'b0;

  logic          model_done = 1'b0;
  logic          man_done = 1'b0;
  logic [YW-1:0] model_y = '0;
  logic [YW-1:0] man_y = '0;
  logic [DW-1:0] smp = '0;
  bit            fir_en = 1'b0;
  bit            sp = 1'b0;

  assign fir_done_i = model_done | man_done;
  assign y_i        = model_done ? model_y : man_y;

  student_fir_sample_feeder #(
    .DATA_SIZE      (DW),
    .DATA_SIZE_Y    (YW),
    .FIFO_DEPTH     (DEPTH),
    .STROBE_CYCLES  (STB),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .enable_i       (enable_i),
    .wr_valid_i     (wr_valid_i),
    .wr_data_i      (wr_data_i),
    .wr_ready_o     (wr_ready_o),
    .level_o        (level_o),
    .valid_strobe_o (valid_strobe_o),
    .sample_o       (sample_o),
    .fir_done_i     (fir_done_i),
    .y_i            (y_i),
    .y_o            (y_o),
    .y_valid_o      (y_valid_o),
    .busy_o         (busy_o),
    .timeout_o      (timeout_o),
    .clr_err_i      (clr_err_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  int n_cmp = 0;
  int n_err = 0;
  logic [YW-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Result monitor: every y_valid_o pops one expected value.
  logic [YW-1:0] e;
  always @(negedge clk_i) begin
    if (rst_ni && y_valid_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL y_unexpected: got %h want none", y_o);
      end else begin
        e = exp_q.pop_front();
        chk("y_sb", y_o, e);
      end
    end
  end

  // Strobe monitor: width, rise/fall cycles, strobe count.
  int  strobes = 0;
  int  run = 0;
  int  rise_cyc = 0;
  int  rise_prev = 0;
  int  fall_cyc = 0;
  bit  strb_q = 1'b0;
  always @(negedge clk_i) begin
    if (valid_strobe_o) begin
      if (!strb_q) begin
        strobes++;
        rise_prev = rise_cyc;
        rise_cyc  = cyc;
      end
      run++;
    end else if (strb_q) begin
      chk("strobe_width", run, STB);
      run      = 0;
      fall_cyc = cyc;
    end
    strb_q = valid_strobe_o;
  end

  // FIR model: done 20 cycles after strobe, y = 2*sample.
  initial begin
    forever begin
      @(negedge clk_i);
      if (valid_strobe_o && !sp && fir_en) begin
        smp = sample_o;
        sp  = 1'b1;
        repeat (20) @(posedge clk_i);
        #1;
        model_y    = 32'(smp) << 1;
        model_done = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 model_done = 1'b0;
      end else begin
        sp = valid_strobe_o;
      end
    end
  end

  int push_cyc = 0;
  task automatic push(input logic [DW-1:0] d);
    wr_valid_i = 1'b1;
    wr_data_i  = d;
    @(posedge clk_i);
    #1;
    wr_valid_i = 1'b0;
    push_cyc   = cyc;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++)
      @(negedge clk_i);
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy_o; i++)
      @(negedge clk_i);
    chk("idle", busy_o, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_level"},  level_o, 0);
    chk({tag, "_ready"},  wr_ready_o, 1);
    chk({tag, "_strobe"}, valid_strobe_o, 0);
    chk({tag, "_sample"}, sample_o, 0);
    chk({tag, "_y"},      y_o, 0);
    chk({tag, "_yv"},     y_valid_o, 0);
    chk({tag, "_busy"},   busy_o, 0);
    chk({tag, "_tmo"},    timeout_o, 0);
  endtask

  int p0 = 0;
  int s0 = 0;
  int k  = 0;

  initial begin
    #2;
    chk_reset_vals("rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // Two-sample basic transfer
    enable_i = 1'b1;
    fir_en   = 1'b1;
    exp_q.push_back(32'h0000_2468);
    exp_q.push_back(32'h0000_0084);
    push(16'h1234);
    p0 = push_cyc;
    push(16'h0042);
    wait_drain(400);
    wait_idle(100);
    chk("latency", rise_prev - p0, 1);
    chk("spacing", 32'((rise_cyc - rise_prev) >= STB + 20 + GAP), 1);
    chk("t1_y", y_o, 32'h0000_0084);

    // Fill with enable low, 9th push dropped
    enable_i = 1'b0;
    s0 = strobes;
    for (int i = 0; i < 8; i++) begin
      push(16'(16'h0100 + i));
      exp_q.push_back(32'(16'h0100 + i) << 1);
    end
    chk("full_ready", wr_ready_o, 0);
    chk("full_level", level_o, 8);
    push(16'h0108);
    chk("drop_level", level_o, 8);
    chk("drop_ready", wr_ready_o, 0);
    @(negedge clk_i);
    enable_i = 1'b1;
    wait_drain(1500);
    wait_idle(100);
    repeat (50) @(negedge clk_i);
    chk("eight_strobes", strobes - s0, 8);
    chk("t2_level", level_o, 0);

    // Timeout, then next sample served
    fir_en = 1'b0;
    exp_q.push_back(32'h0000_0EF0);
    push(16'h0777);
    push(16'h0778);
    k = 0;
    while (k < 300 && !timeout_o) begin
      @(negedge clk_i);
      k++;
    end
    chk("tmo_set", timeout_o, 1);
    chk("tmo_lat", cyc - fall_cyc, TMO);
    chk("tmo_y_kept", y_o, 32'h0000_020E);
    fir_en = 1'b1;
    wait_drain(300);
    wait_idle(100);
    chk("tmo_sticky", timeout_o, 1);
    @(negedge clk_i);
    clr_err_i = 1'b1;
    @(negedge clk_i);
    clr_err_i = 1'b0;
    chk("tmo_clr", timeout_o, 0);

    // Done pulses outside WAIT are ignored
    fir_en = 1'b0;
    man_y  = 32'h0000_DEAD;
    push(16'h0055);
    k = 0;
    while (k < 20 && !valid_strobe_o) begin
      @(negedge clk_i);
      k++;
    end
    chk("t4_strobe", valid_strobe_o, 1);
    man_done = 1'b1;
    @(negedge clk_i);
    man_done = 1'b0;
    k = 0;
    while (k < 20 && valid_strobe_o) begin
      @(negedge clk_i);
      k++;
    end
    chk("t4_wait_busy", busy_o, 1);
    man_y = 32'h0000_00AA;
    exp_q.push_back(32'h0000_00AA);
    man_done = 1'b1;
    @(negedge clk_i);
    man_done = 1'b0;
    @(negedge clk_i);
    chk("t4_gap_busy", busy_o, 1);
    man_y    = 32'h0000_BEEF;
    man_done = 1'b1;
    @(negedge clk_i);
    man_done = 1'b0;
    wait_idle(50);
    repeat (3) @(negedge clk_i);
    chk("t4_y_kept", y_o, 32'h0000_00AA);
    chk("t4_drain", exp_q.size(), 0);

    // Reset during WAIT with 3 queued
    for (int i = 0; i < 4; i++) push(16'(16'h0300 + i));
    repeat (10) @(negedge clk_i);
    chk("t5_busy", busy_o, 1);
    chk("t5_level", level_o, 3);
    rst_ni = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("t5_level_rel", level_o, 0);
    s0 = strobes;
    repeat (30) @(negedge clk_i);
    chk("t5_no_strobe", strobes - s0, 0);

    // Simultaneous push/pop at level 4, order across wrap
    enable_i = 1'b0;
    fir_en   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(16'(16'h0200 + i));
      exp_q.push_back(32'(16'h0200 + i) << 1);
    end
    chk("t6_full", wr_ready_o, 0);
    @(negedge clk_i);
    enable_i = 1'b1;
    k = 0;
    while (k < 500 && level_o != 4) begin
      @(negedge clk_i);
      k++;
    end
    enable_i = 1'b0;
    chk("t6_lvl4", level_o, 4);
    wait_idle(200);
    chk("t6_lvl4_idle", level_o, 4);
    enable_i   = 1'b1;
    wr_valid_i = 1'b1;
    wr_data_i  = 16'h0AAA;
    exp_q.push_back(32'h0000_1554);
    @(posedge clk_i);
    #1;
    wr_valid_i = 1'b0;
    chk("t6_pushpop_lvl", level_o, 4);
    chk("t6_popped", busy_o, 1);
    wait_drain(800);
    wait_idle(100);
    chk("t6_empty", level_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
